pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//  Controller for the IO PLL's rst/locked interface. Drives the PLL reset pulse and watches
//  lock with a timeout and retries. Releases a downstream system reset only after lock is stable.
//  Sits beside the PLL and runs on the free-running 100 MHz reference clock, not on a PLL output.
// PARAMETERS
//  PLL_RST_CYCLES      16      cycles pll_rst is held high per reset attempt (>=1)
//  LOCK_TIMEOUT_CYCLES 100000  cycles allowed in WAIT_LOCK before an attempt fails (1 ms @100 MHz)
//  LOCK_STABLE_CYCLES  1024    consecutive synchronized-locked cycles required before release
//  MAX_RETRIES         3       failed attempts tolerated before FAULT
//  SYNC_STAGES         2       flops in the locked synchronizer (>=2)
// PORTS
//  refclk       in   1   reference clock; sole clock of this block
//  rst          in   1   synchronous, active-high reset
//  pll_locked   in   1   PLL locked; asynchronous to refclk
//  pll_rst      out  1   PLL reset, active high
//  sys_rst      out  1   downstream reset, active high
//  ready        out  1   high only in RUN
//  fault        out  1   high only in FAULT
//  lock_loss    out  1   one-cycle pulse when lock drops in RUN
//  retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts since last successful lock
// BEHAVIOUR
//  - Single clock; one synchronous, active-high reset. locked_s = pll_locked after SYNC_STAGES flops.
//  - All outputs are registered. State output values:
//    RESET_PLL: pll_rst=1 sys_rst=1. WAIT_LOCK/STABLE: pll_rst=0 sys_rst=1.
//    RUN: pll_rst=0 sys_rst=0 ready=1. FAULT: pll_rst=1 sys_rst=1 fault=1.
//  - Reset values: state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fault=0, lock_loss=0,
//    retry_count=0, counter=0. Reset mid-sequence aborts immediately and restarts from these values.
//  - RESET_PLL: stay PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
//  - WAIT_LOCK, with locked_s=1: go to STABLE, counter cleared.
//  - WAIT_LOCK, counter reaches LOCK_TIMEOUT_CYCLES-1 with locked_s=0:
//      - if retry_count<MAX_RETRIES: retry_count++, go to RESET_PLL;
//      - otherwise go to FAULT.
//    If lock and timeout occur in the same cycle, lock wins.
//  - STABLE: locked_s=0 at any cycle returns to WAIT_LOCK, with a fresh timeout and no retry
//    increment. After LOCK_STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN and set
//    retry_count=0. sys_rst falls on the entry cycle of RUN.
//  - RUN with locked_s=0: in the next cycle lock_loss=1 for exactly one cycle, sys_rst=1,
//    ready=0. The next state depends on the macro below.
//  - FAULT is terminal until rst.
//  - Counter width is $clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)).
//    It saturates and never wraps.
// CONFIGURATION
//  PLL_RST_SEQ_AUTORECOVER_EN
//    Defined: lock loss in RUN goes to RESET_PLL with retry_count=0, a full re-sequence.
//    Undefined: lock loss in RUN goes to FAULT; the lock_loss pulse is still emitted.
// STRUCTURE
//  - pll_rst_seq_pkg holds:
//      - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT};
//      - default-parameter localparams;
//      - a function computing the counter width.
//  - Sub-module bit_synchronizer (#SYNC_STAGES) for pll_locked. The FSM and counter stay in this module.
// TESTING  (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=8,
//           MAX_RETRIES=2, SYNC_STAGES=2)
//  1. Reset release, pll_locked raised 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles;
//     sys_rst falls 2+8 cycles after the rise, ready=1, retry_count=0.
//  2. pll_locked held 0 -> three pll_rst pulses, retry_count 0->1->2, then FAULT with fault=1,
//     pll_rst=1, sys_rst=1, held until rst.
//  3. Lock glitch low for 1 cycle at STABLE cycle 5 -> back to WAIT_LOCK, retry_count unchanged;
//     release occurs 8 full stable cycles after relock.
//  4. In RUN, drop pll_locked -> lock_loss single pulse 3 cycles later, sys_rst=1, ready=0.
//     With AUTORECOVER_EN: new 4-cycle pll_rst. Without it: fault=1.
//  5. Assert rst during WAIT_LOCK with retry_count=1 -> next cycle all outputs at reset values.
//  6. Lock arriving on the timeout cycle of attempt 2 -> STABLE entered, no FAULT, retry_count=2
//     until RUN, then 0.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
// pll_rst_seq_pkg: state encoding, default parameters and counter sizing for pll_reset_sequencer
package pll_rst_seq_pkg;
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 100000;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES = 3;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous level
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk) ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock sequencing with timeout, retries and stable-lock release; PLL_RST_SEQ_AUTORECOVER_EN re-sequences on lock loss
module pll_reset_sequencer
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             sys_rst,
  output logic                             ready,
  output logic                             fault,
  output logic                             lock_loss,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);
  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  state_t state;
  logic [CW-1:0] cnt, cnt_inc;
  logic locked_s;
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (.clk(refclk), .d(pll_locked), .q(locked_s));
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_loss   <= 1'b0;
      retry_count <= '0;
    end else begin
      lock_loss <= 1'b0;
      case (state)
        RESET_PLL:
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else cnt <= cnt_inc;
        WAIT_LOCK:
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_count < RW'(MAX_RETRIES)) begin
              state       <= RESET_PLL;
              retry_count <= retry_count + 1'b1;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else cnt <= cnt_inc;
        STABLE:
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state       <= RUN;
            cnt         <= '0;
            sys_rst     <= 1'b0;
            ready       <= 1'b1;
            retry_count <= '0;
          end else cnt <= cnt_inc;
        RUN:
          if (!locked_s) begin
            lock_loss <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            pll_rst   <= 1'b1;
            cnt       <= '0;
`ifdef PLL_RST_SEQ_AUTORECOVER_EN
            state       <= RESET_PLL;
            retry_count <= '0;
`else
            state <= FAULT;
            fault <= 1'b1;
`endif
          end
        default: ;
      endcase
    end
  end
endmodule
